// File: rtl/divide_freq_prog.sv
// Programmable, pausable clock-enable generator: main divider with runtime-loadable divisor
// plus a cascaded sub divider. Define DIVIDE_FREQ_PROG_SQUARE_EN to add the square output.
module divide_freq_prog #(
    parameter int unsigned WIDTH       = 7,
    parameter int unsigned DIV_DEFAULT = 100,
    parameter int unsigned SUB_DIV     = 60
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_value,
    output logic             div_ack,
    output logic             tick,
    output logic             tick_sub,
    output logic [WIDTH-1:0] count
`ifdef DIVIDE_FREQ_PROG_SQUARE_EN
    ,
    output logic             square
`endif
);

    localparam int unsigned SUB_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_DIV - 1);
    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_DEFAULT);

    if (DIV_DEFAULT < 1 || DIV_DEFAULT > (2 ** WIDTH) - 1) begin : g_bad_div_default
        $error("DIV_DEFAULT out of range for WIDTH");
    end
    if (SUB_DIV < 1) begin : g_bad_sub_div
        $error("SUB_DIV must be at least 1");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [WIDTH-1:0] div_active_q, div_active_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_sub_q, ack_q;
    logic             tick_d, tick_sub_d, ack_d;

    logic [WIDTH-1:0] div_last;
    logic             wrap;
    logic             sub_wrap;
    logic             load_ok;

    assign div_last = div_active_q - WIDTH'(1);
    assign wrap     = enable && (count_q == div_last);
    assign sub_wrap = wrap && (sub_q == SUB_LAST);
    assign load_ok  = div_load && (div_value != '0);

    always_comb begin
        count_d = count_q;
        if (enable) begin
            count_d = wrap ? '0 : count_q + WIDTH'(1);
        end
    end

    always_comb begin
        sub_d = sub_q;
        if (wrap) begin
            sub_d = sub_wrap ? '0 : sub_q + SUB_W'(1);
        end
    end

    // A load on the wrap edge itself is folded in before the apply decision, so it takes
    // effect at that same wrap; a later load simply overwrites an unapplied pending value.
    always_comb begin
        pend_val_d   = load_ok ? div_value : pend_val_q;
        pend_d       = pend_q | load_ok;
        div_active_d = div_active_q;
        ack_d        = 1'b0;
        if (wrap && pend_d) begin
            div_active_d = pend_val_d;
            pend_d       = 1'b0;
            ack_d        = 1'b1;
        end
    end

    assign tick_d     = wrap;
    assign tick_sub_d = sub_wrap;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q      <= '0;
            sub_q        <= '0;
            div_active_q <= DIV_RST;
            pend_val_q   <= '0;
            pend_q       <= 1'b0;
            tick_q       <= 1'b0;
            tick_sub_q   <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            count_q      <= count_d;
            sub_q        <= sub_d;
            div_active_q <= div_active_d;
            pend_val_q   <= pend_val_d;
            pend_q       <= pend_d;
            tick_q       <= tick_d;
            tick_sub_q   <= tick_sub_d;
            ack_q        <= ack_d;
        end
    end

    assign count    = count_q;
    assign tick     = tick_q;
    assign tick_sub = tick_sub_q;
    assign div_ack  = ack_q;

`ifdef DIVIDE_FREQ_PROG_SQUARE_EN
    logic square_q, square_d;

    // Compared against the divisor in force for the next period, so a new divisor's duty
    // starts cleanly at the wrap that applies it.
    always_comb begin
        square_d = square_q;
        if (enable) begin
            square_d = (count_d < (div_active_d >> 1));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            square_q <= 1'b0;
        end else begin
            square_q <= square_d;
        end
    end

    assign square = square_q;
`endif

    a_sub_with_tick : assert property (@(posedge clock) disable iff (reset) tick_sub |-> tick);
    a_ack_with_tick : assert property (@(posedge clock) disable iff (reset) div_ack |-> tick);

endmodule
